// File: rtl/regfile_access_master.sv
// regfile_access_master
//   Initiator-side controller for the register file access port. Takes one
//   read/write command at a time on a valid/ready channel, issues exactly one
//   register file access (WrEn or RdEn pulse), and returns one response per
//   command on a valid/ready channel.
//
//   Optional feature macro: RFAM_ADDR_CHECK_EN
//     defined   : commands with cmd_addr >= NUM_REGS are not issued; they get
//                 an immediate response with rsp_err=1 and rsp_rdata=0.
//     undefined : every command is issued; rsp_err is tied to 0.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready     command handshake
//   cmd_wr/addr/wdata   command type (1=write), target register, write data
//   rsp_valid/ready     response handshake
//   rsp_wr/rdata/err    echoed type, read data (0 for writes), address error
//   busy                high whenever the FSM is not IDLE
//   WrEn/RdEn/Address/WrData  register file access port (registered)
//   RdData              register file read data, valid RD_LATENCY cycles
//                       after the RdEn cycle
module regfile_access_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_wr,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    // WAIT_RD lasts RD_LATENCY cycles; the counter runs 0..RD_LATENCY-1 (max 3).
    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

    state_t                state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_wr_q, rsp_wr_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            lat_cnt_q, lat_cnt_d;
`ifdef RFAM_ADDR_CHECK_EN
    logic                  rsp_err_q, rsp_err_d;
    logic                  addr_bad;

    assign addr_bad = int'(cmd_addr) >= NUM_REGS;
    assign rsp_err  = rsp_err_q;
`else
    assign rsp_err  = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign WrEn      = wr_en_q;
    assign RdEn      = rd_en_q;
    assign Address   = addr_q;
    assign WrData    = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_rdata = rsp_rdata_q;

    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;      // enables are single-cycle pulses
        rd_en_d     = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_rdata_d = rsp_rdata_q;
        lat_cnt_d   = lat_cnt_q;
`ifdef RFAM_ADDR_CHECK_EN
        rsp_err_d   = rsp_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
`ifdef RFAM_ADDR_CHECK_EN
                    if (addr_bad) begin
                        // Out-of-range: never touch the register file.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_wr_d    = cmd_wr;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        wr_en_d   = cmd_wr;
                        rd_en_d   = ~cmd_wr;
                        rsp_err_d = 1'b0;
                        state_d   = ISSUE;
                    end
`else
                    wr_en_d = cmd_wr;
                    rd_en_d = ~cmd_wr;
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                // The enable registers still hold the command type here.
                if (wr_en_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_wr_d    = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    state_d   = WAIT_RD;
                    rsp_wr_d  = 1'b0;
                    lat_cnt_d = '0;
                end
            end
            WAIT_RD: begin
                if (lat_cnt_q == LAT_LAST) begin
                    rsp_rdata_d = RdData;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
            lat_cnt_q   <= '0;
`ifdef RFAM_ADDR_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_rdata_q <= rsp_rdata_d;
            lat_cnt_q   <= lat_cnt_d;
`ifdef RFAM_ADDR_CHECK_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_access_master.sv
// Bench for regfile_access_master. Two instances share the command and
// response-ready stimulus: A (NUM_REGS=16, RD_LATENCY=1) and
// B (NUM_REGS=12, RD_LATENCY=3). Each drives its own register file model.
module tb_regfile_access_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_wr, rsp_ready;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;

    logic       a_cmd_ready, a_rsp_valid, a_rsp_wr, a_rsp_err, a_busy, a_WrEn, a_RdEn;
    logic [3:0] a_Address;
    logic [7:0] a_rsp_rdata, a_WrData, a_RdData;
    logic       b_cmd_ready, b_rsp_valid, b_rsp_wr, b_rsp_err, b_busy, b_WrEn, b_RdEn;
    logic [3:0] b_Address;
    logic [7:0] b_rsp_rdata, b_WrData, b_RdData;

`ifdef RFAM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_access_master #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_REGS(16), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(a_rsp_wr),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .busy(a_busy),
        .WrEn(a_WrEn), .RdEn(a_RdEn), .Address(a_Address), .WrData(a_WrData),
        .RdData(a_RdData)
    );

    regfile_access_master #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_REGS(12), .RD_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(b_rsp_wr),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy),
        .WrEn(b_WrEn), .RdEn(b_RdEn), .Address(b_Address), .WrData(b_WrData),
        .RdData(b_RdData)
    );

    // Register file models. Outside the valid read cycle RdData shows 0xEE so
    // sampling in the wrong cycle is visible.
    logic [7:0] a_mem [16];
    logic [7:0] b_mem [16];
    logic [7:0] a_p0, b_p0, b_p1, b_p2;
    assign a_RdData = a_p0;
    assign b_RdData = b_p2;

    always @(posedge clk) begin
        if (a_WrEn) a_mem[a_Address] <= a_WrData;
        a_p0 <= a_RdEn ? a_mem[a_Address] : 8'hEE;
        if (b_WrEn) b_mem[b_Address] <= b_WrData;
        b_p0 <= b_RdEn ? b_mem[b_Address] : 8'hEE;
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end

    task automatic chk(input int tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL t%0d %s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    // One command through both instances with rsp_ready=1; data is the write
    // data for writes and the expected read data for reads.
    task automatic run_cmd(input int idx, input bit wr, input logic [3:0] addr, input logic [7:0] data);
        int a_we = 0, a_re = 0, a_rv = 0, a_cyc = 0, a_both = 0;
        int b_we = 0, b_re = 0, b_rv = 0, b_cyc = 0, b_both = 0;
        logic [3:0] a_pa = '0, b_pa = '0;
        logic [7:0] a_pd = '0, b_pd = '0, a_rd = '0, b_rd = '0;
        logic a_rw = 1'b0, a_er = 1'b0, b_rw = 1'b0, b_er = 1'b0;
        bit b_err;
        int a_lat, b_lat;
        b_err = CHK && (addr >= 4'd12);
        a_lat = wr ? 2 : 3;
        b_lat = b_err ? 1 : (wr ? 2 : 5);
        @(negedge clk);
        chk(idx, "a_ready_before", a_cmd_ready, 1);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; rsp_ready = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (a_WrEn) begin a_we++; a_pa = a_Address; a_pd = a_WrData; end
            if (a_RdEn) begin a_re++; a_pa = a_Address; end
            if (a_WrEn && a_RdEn) a_both++;
            if (a_rsp_valid) begin
                a_rv++;
                if (a_cyc == 0) begin a_cyc = k; a_rd = a_rsp_rdata; a_rw = a_rsp_wr; a_er = a_rsp_err; end
            end
            if (b_WrEn) begin b_we++; b_pa = b_Address; b_pd = b_WrData; end
            if (b_RdEn) begin b_re++; b_pa = b_Address; end
            if (b_WrEn && b_RdEn) b_both++;
            if (b_rsp_valid) begin
                b_rv++;
                if (b_cyc == 0) begin b_cyc = k; b_rd = b_rsp_rdata; b_rw = b_rsp_wr; b_er = b_rsp_err; end
            end
        end
        chk(idx, "a_wren_cycles", a_we, wr ? 1 : 0);
        chk(idx, "a_rden_cycles", a_re, wr ? 0 : 1);
        chk(idx, "a_both_en", a_both, 0);
        chk(idx, "a_address", a_pa, addr);
        chk(idx, "a_wrdata", a_pd, wr ? data : 8'h00);
        chk(idx, "a_rsp_latency", a_cyc, a_lat);
        chk(idx, "a_rsp_count", a_rv, 1);
        chk(idx, "a_rsp_wr", a_rw, wr);
        chk(idx, "a_rsp_rdata", a_rd, wr ? 8'h00 : data);
        chk(idx, "a_rsp_err", a_er, 0);
        chk(idx, "b_wren_cycles", b_we, (wr && !b_err) ? 1 : 0);
        chk(idx, "b_rden_cycles", b_re, (!wr && !b_err) ? 1 : 0);
        chk(idx, "b_both_en", b_both, 0);
        chk(idx, "b_address", b_pa, b_err ? 4'd0 : addr);
        chk(idx, "b_wrdata", b_pd, (wr && !b_err) ? data : 8'h00);
        chk(idx, "b_rsp_latency", b_cyc, b_lat);
        chk(idx, "b_rsp_count", b_rv, 1);
        chk(idx, "b_rsp_wr", b_rw, wr);
        chk(idx, "b_rsp_rdata", b_rd, (wr || b_err) ? 8'h00 : data);
        chk(idx, "b_rsp_err", b_er, b_err);
    endtask

    typedef struct {
        bit         wr;
        logic [3:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int bad;
        vecs[0]  = '{1'b1, 4'd3,  8'hA5};
        vecs[1]  = '{1'b0, 4'd3,  8'hA5};
        vecs[2]  = '{1'b1, 4'd0,  8'h3C};
        vecs[3]  = '{1'b0, 4'd0,  8'h3C};
        vecs[4]  = '{1'b1, 4'd7,  8'h77};
        vecs[5]  = '{1'b0, 4'd7,  8'h77};
        vecs[6]  = '{1'b1, 4'd13, 8'h5A};
        vecs[7]  = '{1'b0, 4'd13, 8'h5A};
        vecs[8]  = '{1'b1, 4'd11, 8'hC3};
        vecs[9]  = '{1'b0, 4'd11, 8'hC3};
        vecs[10] = '{1'b1, 4'd15, 8'hFF};
        vecs[11] = '{1'b0, 4'd15, 8'hFF};
        vecs[12] = '{1'b0, 4'd3,  8'hA5};

        // Reset and idle
        rst = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(200, "rst_a_cmd_ready", a_cmd_ready, 1);
        chk(200, "rst_a_busy", a_busy, 0);
        chk(200, "rst_a_outputs", {a_rsp_valid, a_rsp_wr, a_rsp_err, a_WrEn, a_RdEn, a_Address, a_WrData, a_rsp_rdata}, 0);
        chk(200, "rst_b_cmd_ready", b_cmd_ready, 1);
        chk(200, "rst_b_outputs", {b_rsp_valid, b_busy, b_WrEn, b_RdEn, b_Address, b_WrData, b_rsp_rdata}, 0);
        rst = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_WrEn || a_RdEn || a_rsp_valid || a_busy || !a_cmd_ready) bad++;
            if (b_WrEn || b_RdEn || b_rsp_valid || b_busy || !b_cmd_ready) bad++;
        end
        chk(201, "idle_no_activity", bad, 0);

        // Table-driven commands
        for (int i = 0; i < 13; i++) run_cmd(i, vecs[i].wr, vecs[i].addr, vecs[i].data);

        // Response back-pressure: read addr 7, hold rsp_ready low, second
        // command waiting on cmd_valid.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd7; rsp_ready = 1'b0;
        @(posedge clk);
        bad = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin cmd_wr = 1'b1; cmd_addr = 4'd2; cmd_wdata = 8'h42; end
            if (a_cmd_ready || b_cmd_ready || a_WrEn || b_WrEn) bad++;
            if (k >= 3 && (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 8'h77 || a_rsp_wr !== 1'b0)) bad++;
            if (k >= 5 && (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 8'h77 || b_rsp_wr !== 1'b0)) bad++;
        end
        chk(300, "bp_hold_stable", bad, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk(301, "bp_a_ready_after", a_cmd_ready, 1);
        chk(301, "bp_a_valid_cleared", a_rsp_valid, 0);
        chk(301, "bp_b_ready_after", b_cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk(302, "bp_a_second_wren", {a_WrEn, a_Address, a_WrData}, {1'b1, 4'd2, 8'h42});
        chk(302, "bp_b_second_wren", {b_WrEn, b_Address, b_WrData}, {1'b1, 4'd2, 8'h42});
        @(negedge clk);
        chk(303, "bp_a_second_rsp", {a_rsp_valid, a_rsp_wr, a_rsp_rdata}, {1'b1, 1'b1, 8'h00});
        chk(303, "bp_b_second_rsp", {b_rsp_valid, b_rsp_wr, b_rsp_rdata}, {1'b1, 1'b1, 8'h00});
        repeat (2) @(negedge clk);

        // Reset in WAIT_RD
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk(400, "mid_rden_pulse", {a_RdEn, b_RdEn}, 2'b11);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk(401, "mid_a_abort", {a_busy, a_cmd_ready, a_RdEn, a_rsp_valid}, 4'b0100);
        chk(401, "mid_b_abort", {b_busy, b_cmd_ready, b_RdEn, b_rsp_valid}, 4'b0100);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_rsp_valid || b_rsp_valid || a_RdEn || b_RdEn || a_busy || b_busy) bad++;
        end
        chk(402, "mid_no_response", bad, 0);

        // Reset in ISSUE drops the WrEn pulse at once
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd5; cmd_wdata = 8'h99;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk(403, "issue_wren_pulse", {a_WrEn, b_WrEn}, 2'b11);
        #1 rst = 1'b0;
        #1;
        chk(404, "issue_wren_dropped", {a_WrEn, b_WrEn, a_busy, b_busy}, 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        // Normal operation after the aborted commands
        run_cmd(500, 1'b1, 4'd1, 8'h11);
        run_cmd(501, 1'b0, 4'd1, 8'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_access_master.md
Name: regfile_access_master

Overview:
- Initiator-side controller that drives the register file's WrEn/RdEn/Address/WrData port and collects RdData.
- Accepts one read or write command at a time on a valid/ready command channel and issues exactly one register file access per command.
- Returns one response per command on a valid/ready response channel.
- Sits between the ALU/control logic and the register file storage block.

Parameters:
- ADDR_WIDTH, 4, width of Address and cmd_addr.
- DATA_WIDTH, 8, width of WrData, RdData, cmd_wdata, rsp_rdata.
- NUM_REGS, 16, number of implemented registers; legal addresses are 0..NUM_REGS-1.
- RD_LATENCY, 1, cycles from the RdEn cycle until RdData is valid; range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target register.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_wr  out  1  echo of the command type.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  address error; see Optional Feature.
- busy  out  1  high in any state other than IDLE.
- WrEn  out  1  register file write enable.
- RdEn  out  1  register file read enable.
- Address  out  ADDR_WIDTH  register file address.
- WrData  out  DATA_WIDTH  register file write data.
- RdData  in  DATA_WIDTH  register file read data.

Behaviour:
- Reset (rst=0, asynchronous) forces the FSM to IDLE.
- All outputs reset to 0: WrEn, RdEn, Address, WrData, rsp_valid, rsp_wr, rsp_rdata, rsp_err and busy. The exception is cmd_ready, which reads 1 after reset.
- All outputs except cmd_ready and busy are registered. cmd_ready = (state==IDLE). busy = (state!=IDLE).
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE: a handshake (cmd_valid & cmd_ready) at edge E latches cmd_wr, cmd_addr and cmd_wdata and moves to ISSUE.
  - Address and WrData are loaded at E.
  - WrEn=cmd_wr and RdEn=~cmd_wr are asserted in the cycle after E.
- ISSUE lasts exactly one cycle.
  - WrEn and RdEn are never high together, and each is high for exactly one cycle per command.
  - Write: next state is RESP; rsp_valid=1, rsp_wr=1, rsp_rdata=0 in the cycle after the WrEn cycle.
  - Read: next state is WAIT_RD.
- WAIT_RD: a latency counter counts RD_LATENCY cycles after the RdEn cycle.
  - RdData is sampled at the end of cycle (RdEn cycle + RD_LATENCY) into rsp_rdata.
  - Next state is RESP, with rsp_valid=1 and rsp_wr=0.
  - Total read latency from command handshake edge to rsp_valid: RD_LATENCY+2 cycles. Write latency is 2 cycles.
- RESP: rsp_valid, rsp_wr, rsp_rdata and rsp_err are held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready, clear rsp_valid and return to IDLE. cmd_ready rises in the following cycle.
  - There is no command/response overlap.
- Address and WrData keep their last values between commands; they are only sampled by the register file under WrEn/RdEn.
- Back-pressure:
  - cmd_valid may stay high while busy; no command is accepted until IDLE.
  - cmd_* inputs are don't-care except at the handshake edge.
- Reset mid-operation: asynchronous reset in any state aborts the transaction.
  - Any WrEn/RdEn pulse drops immediately.
  - A pending response is discarded; no response is produced for the aborted command.
- Address width: cmd_addr is used unmodified. No wrap or truncation is applied.

Optional Feature:
- Macro: RFAM_ADDR_CHECK_EN.
- Defined:
  - A command with cmd_addr >= NUM_REGS skips ISSUE and WAIT_RD.
  - WrEn and RdEn stay 0 for that command.
  - It goes straight to RESP with rsp_err=1 and rsp_rdata=0, so the response appears 1 cycle after the handshake.
  - Legal commands have rsp_err=0.
- Undefined: no check is made; every command is issued to the register file and rsp_err is tied to 0.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then release -> cmd_ready=1; rsp_valid, WrEn, RdEn and busy = 0; no pulses while cmd_valid=0.
- Write then read: write addr 3, data 0xA5 -> one WrEn cycle with Address=3, WrData=0xA5, and rsp_valid with rsp_wr=1 two cycles after the handshake. A following read of addr 3 -> one RdEn cycle, and rsp_rdata=0xA5 at handshake+3 (RD_LATENCY=1).
- Response back-pressure: read addr 7 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held stable, cmd_ready=0, a second cmd_valid is not accepted; after rsp_ready=1 the second command is accepted one cycle later.
- Latency sweep: RD_LATENCY=3, read addr 0 holding 0x3C -> rsp_valid at handshake+5 with rsp_rdata=0x3C; RdEn high exactly one cycle.
- Reset mid-read: assert rst in the WAIT_RD state -> RdEn=0 and rsp_valid=0 immediately; no response after release; the next write to addr 1 completes normally.
- Address check, NUM_REGS=12: with RFAM_ADDR_CHECK_EN, write addr 13 -> no WrEn, rsp_err=1 at handshake+1. Without the macro, the same command -> WrEn pulses with Address=13 and rsp_err=0.
